// File: rtl/cmu_assoc.sv
// Two-way set-associative write-back cache controller with per-set LRU and
// whole-cache flush; stalls the requester while lines move over a word-wide bus.
module cmu_assoc #(
   parameter int INDEX_BITS       = 4,
   parameter int LINE_WORDS_WIDTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr_rw,
   input  logic        en_r,
   input  logic        en_w,
   input  logic [31:0] data_w,
   output logic [31:0] data_r,
   input  logic        flush,
   output logic        stall,
   output logic        mem_cs_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_ack_i
);
   localparam int SETS       = 1 << INDEX_BITS;
   localparam int LINE_WORDS = 1 << LINE_WORDS_WIDTH;
   localparam int TAG_BITS   = 32 - INDEX_BITS - LINE_WORDS_WIDTH - 2;
   localparam logic [LINE_WORDS_WIDTH-1:0] LAST_WORD = '1;
   localparam logic [INDEX_BITS:0]         LAST_LINE = '1;

   typedef enum logic [2:0] {
      IDLE, BACK, BACK_WAIT, FILL, FILL_WAIT, FLUSH_SCAN, FLUSH_BACK
   } state_t;

   state_t state;
   logic [SETS-1:0][1:0]        valid, dirty;
   logic [SETS-1:0]             lru;
   logic [TAG_BITS-1:0]         tag_mem  [SETS][2];
   logic [31:0]                 data_mem [SETS][2][LINE_WORDS];
   logic [LINE_WORDS_WIDTH-1:0] word_cnt;
   logic [INDEX_BITS:0]         scan_ptr;
   logic                        vway;

   logic [TAG_BITS-1:0]         a_tag;
   logic [INDEX_BITS-1:0]       a_idx, s_set;
   logic [LINE_WORDS_WIDTH-1:0] a_word;
   logic                        s_way, hit0, hit1, hit, req, miss, victim, wr_hit;

   assign a_tag  = addr_rw[31 -: TAG_BITS];
   assign a_idx  = addr_rw[LINE_WORDS_WIDTH+2 +: INDEX_BITS];
   assign a_word = addr_rw[2 +: LINE_WORDS_WIDTH];
   assign s_set  = scan_ptr[INDEX_BITS:1];
   assign s_way  = scan_ptr[0];

   assign hit0   = valid[a_idx][0] && (tag_mem[a_idx][0] == a_tag);
   assign hit1   = valid[a_idx][1] && (tag_mem[a_idx][1] == a_tag);
   assign hit    = hit0 | hit1;
   assign req    = en_r | en_w;
   assign miss   = req & ~hit;
   assign victim = !valid[a_idx][0] ? 1'b0 :
                   !valid[a_idx][1] ? 1'b1 : lru[a_idx];
   assign wr_hit = (state == IDLE) && !flush && en_w && hit;

   assign data_r = hit0 ? data_mem[a_idx][0][a_word] :
                   hit1 ? data_mem[a_idx][1][a_word] : 32'd0;
   assign stall  = (state != IDLE) | flush | miss;

   always_comb begin
      mem_cs_o   = 1'b0;
      mem_we_o   = 1'b0;
      mem_addr_o = 32'd0;
      mem_data_o = 32'd0;
      case (state)
         BACK: begin
            mem_cs_o   = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = {tag_mem[a_idx][vway], a_idx, word_cnt, 2'b00};
            mem_data_o = data_mem[a_idx][vway][word_cnt];
         end
         FLUSH_BACK: begin
            mem_cs_o   = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = {tag_mem[s_set][s_way], s_set, word_cnt, 2'b00};
            mem_data_o = data_mem[s_set][s_way][word_cnt];
         end
         FILL: begin
            mem_cs_o   = 1'b1;
            mem_addr_o = {a_tag, a_idx, word_cnt, 2'b00};
         end
         default: ;
      endcase
   end

   // Tag/data storage carries no reset; valid bits gate every use.
   always_ff @(posedge clk) begin
      if (wr_hit)
         data_mem[a_idx][hit1][a_word] <= data_w;
      if (state == FILL && mem_ack_i)
         data_mem[a_idx][vway][word_cnt] <= mem_data_i;
      if (state == FILL_WAIT)
         tag_mem[a_idx][vway] <= a_tag;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         word_cnt <= '0;
         scan_ptr <= '0;
         vway     <= 1'b0;
         valid    <= '0;
         dirty    <= '0;
         lru      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush) begin
                  scan_ptr <= '0;
                  word_cnt <= '0;
                  state    <= FLUSH_SCAN;
               end else if (req && hit) begin
                  lru[a_idx] <= ~hit1;
                  if (en_w) dirty[a_idx][hit1] <= 1'b1;
               end else if (miss) begin
                  // The victim is invalidated up front so a half-refilled line never hits.
                  vway                 <= victim;
                  word_cnt             <= '0;
                  valid[a_idx][victim] <= 1'b0;
                  dirty[a_idx][victim] <= 1'b0;
                  state <= (valid[a_idx][victim] && dirty[a_idx][victim]) ? BACK : FILL;
               end
            end
            BACK: if (mem_ack_i) begin
               word_cnt <= word_cnt + 1'b1;
               if (word_cnt == LAST_WORD) state <= BACK_WAIT;
            end
            BACK_WAIT: begin
               word_cnt <= '0;
               state    <= FILL;
            end
            FILL: if (mem_ack_i) begin
               word_cnt <= word_cnt + 1'b1;
               if (word_cnt == LAST_WORD) state <= FILL_WAIT;
            end
            FILL_WAIT: begin
               valid[a_idx][vway] <= 1'b1;
               dirty[a_idx][vway] <= 1'b0;
               state              <= IDLE;
            end
            FLUSH_SCAN: begin
               if (valid[s_set][s_way] && dirty[s_set][s_way]) begin
                  word_cnt <= '0;
                  state    <= FLUSH_BACK;
               end else begin
                  valid[s_set][s_way] <= 1'b0;
                  dirty[s_set][s_way] <= 1'b0;
                  if (scan_ptr == LAST_LINE) begin
                     lru      <= '0;
                     scan_ptr <= '0;
                     state    <= IDLE;
                  end else begin
                     scan_ptr <= scan_ptr + 1'b1;
                  end
               end
            end
            FLUSH_BACK: if (mem_ack_i) begin
               word_cnt <= word_cnt + 1'b1;
               if (word_cnt == LAST_WORD) begin
                  valid[s_set][s_way] <= 1'b0;
                  dirty[s_set][s_way] <= 1'b0;
                  // On the final line the pointer stays put; the rescan sees it clean and finishes.
                  if (scan_ptr != LAST_LINE) scan_ptr <= scan_ptr + 1'b1;
                  state <= FLUSH_SCAN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cmu_assoc.sv
// Directed bench for cmu_assoc: a vector table of CPU accesses against a
// behavioural word memory, plus hand sequences for flush, wait states and reset.
module tb_cmu_assoc;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr_rw, data_w, data_r;
   logic        en_r, en_w, flush, stall;
   logic        mem_cs_o, mem_we_o, mem_ack_i;
   logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

   cmu_assoc dut (
      .clk(clk), .rst(rst), .addr_rw(addr_rw), .en_r(en_r), .en_w(en_w),
      .data_w(data_w), .data_r(data_r), .flush(flush), .stall(stall),
      .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
   );

   always #5 clk = ~clk;

   int passed = 0, total = 0;
   int wr_cnt = 0, rd_cnt = 0, unstable = 0, ack_delay = 0, wait_cnt = 0;
   logic [31:0] mem_w [logic [31:0]];
   logic        prev_cs = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
   logic [31:0] prev_addr = 32'd0;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // Memory model: decides the ack on the falling edge so it is stable for the next rising edge.
   always @(negedge clk) begin
      if (mem_cs_o && prev_cs && !prev_ack && (mem_addr_o !== prev_addr || mem_we_o !== prev_we))
         unstable++;
      if (mem_cs_o && wait_cnt >= ack_delay) begin
         mem_ack_i = 1'b1;
         wait_cnt  = 0;
         if (mem_we_o) begin
            mem_w[mem_addr_o] = mem_data_o;
            wr_cnt++;
         end else begin
            mem_data_i = mem_w.exists(mem_addr_o) ? mem_w[mem_addr_o] : pat(mem_addr_o);
            rd_cnt++;
         end
      end else begin
         mem_ack_i = 1'b0;
         wait_cnt  = mem_cs_o ? wait_cnt + 1 : 0;
      end
      prev_cs   = mem_cs_o;
      prev_ack  = mem_ack_i;
      prev_we   = mem_we_o;
      prev_addr = mem_addr_o;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Drives one access at posedge+1 and counts stalled cycles until completion.
   task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int cyc, output logic [31:0] rd);
      en_r = r; en_w = w; addr_rw = a; data_w = d; cyc = 0;
      #1;
      while (stall && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      rd = data_r;
      @(posedge clk); #1;
      en_r = 1'b0; en_w = 1'b0;
   endtask

   task automatic do_flush(output int cyc);
      flush = 1'b1; cyc = 0;
      #1;
      while (stall && cyc < 300) begin
         @(posedge clk); #1;
         flush = 1'b0;
         cyc++;
      end
      flush = 1'b0;
   endtask

   typedef struct {
      logic        r, w;
      logic [31:0] addr, wd;
      int          cyc;
      logic [31:0] rd;
      int          wr, rdn;
   } vec_t;

   vec_t tbl[10];
   int          cyc;
   logic [31:0] rd;

   initial begin
      // read/write, addr, wdata, stall cycles, data_r, bus writes, bus reads
      tbl[0] = '{1, 0, 32'h1040, 0,            6,  pat(32'h1040), 0, 4};
      tbl[1] = '{0, 1, 32'h1044, 32'hDEADBEEF, 0,  pat(32'h1044), 0, 0};
      tbl[2] = '{1, 0, 32'h1044, 0,            0,  32'hDEADBEEF,  0, 0};
      tbl[3] = '{1, 0, 32'h2040, 0,            6,  pat(32'h2040), 0, 4};
      tbl[4] = '{1, 0, 32'h3040, 0,            11, pat(32'h3040), 4, 4};
      tbl[5] = '{1, 0, 32'h2044, 0,            0,  pat(32'h2044), 0, 0};
      tbl[6] = '{1, 0, 32'h1040, 0,            6,  pat(32'h1040), 0, 4};
      tbl[7] = '{1, 0, 32'h1044, 0,            0,  32'hDEADBEEF,  0, 0};
      tbl[8] = '{0, 1, 32'h2048, 32'h12345678, 0,  pat(32'h2048), 0, 0};
      tbl[9] = '{1, 0, 32'h0010, 0,            6,  pat(32'h0010), 0, 4};

      rst = 1'b0; en_r = 0; en_w = 0; flush = 0; addr_rw = 32'h1040; data_w = 0;
      mem_ack_i = 0; mem_data_i = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs",    {31'd0, mem_cs_o}, 32'd0);
      chk("rst_we",    {31'd0, mem_we_o}, 32'd0);
      chk("rst_addr",  mem_addr_o, 32'd0);
      chk("rst_mdata", mem_data_o, 32'd0);
      chk("rst_stall_idle", {31'd0, stall}, 32'd0);
      en_r = 1'b1; #1;
      chk("rst_data_r", data_r, 32'd0);
      chk("rst_stall_req", {31'd0, stall}, 32'd1);
      en_r = 1'b0; flush = 1'b1; #1;
      chk("rst_stall_flush", {31'd0, stall}, 32'd1);
      flush = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         wr_cnt = 0; rd_cnt = 0;
         access(tbl[i].r, tbl[i].w, tbl[i].addr, tbl[i].wd, cyc, rd);
         chk($sformatf("v%0d_cyc", i),  cyc,    tbl[i].cyc);
         chk($sformatf("v%0d_data", i), rd,     tbl[i].rd);
         chk($sformatf("v%0d_wr", i),   wr_cnt, tbl[i].wr);
         chk($sformatf("v%0d_rd", i),   rd_cnt, tbl[i].rdn);
      end
      chk("wb_1044", mem_w.exists(32'h1044) ? mem_w[32'h1044] : 32'hX, 32'hDEADBEEF);
      chk("wb_1040", mem_w.exists(32'h1040) ? mem_w[32'h1040] : 32'hX, pat(32'h1040));

      // Flush with the single dirty line holding 0x2048.
      wr_cnt = 0;
      do_flush(cyc);
      chk("flush_wr", wr_cnt, 4);
      chk("flush_2048", mem_w.exists(32'h2048) ? mem_w[32'h2048] : 32'hX, 32'h12345678);
      wr_cnt = 0;
      access(1, 0, 32'h1044, 0, cyc, rd);
      chk("post_flush_cyc_a", cyc, 6);
      chk("post_flush_rd_a", rd, 32'hDEADBEEF);
      access(1, 0, 32'h2048, 0, cyc, rd);
      chk("post_flush_cyc_b", cyc, 6);
      chk("post_flush_rd_b", rd, 32'h12345678);
      chk("post_flush_wr", wr_cnt, 0);
      do_flush(cyc);
      chk("clean_flush_cyc", cyc, 33);
      chk("clean_flush_wr", wr_cnt, 0);

      // Three idle cycles before each refill ack.
      ack_delay = 3; unstable = 0;
      access(1, 0, 32'h0050, 0, cyc, rd);
      chk("wait_cyc", cyc, 18);
      chk("wait_rd", rd, pat(32'h0050));
      chk("wait_stable", unstable, 0);
      ack_delay = 0;

      // Make 0x50 dirty, fill the other way, then abort the writeback with reset.
      access(0, 1, 32'h0054, 32'hCAFEF00D, cyc, rd);
      chk("dirty_hit_cyc", cyc, 0);
      access(1, 0, 32'h1050, 0, cyc, rd);
      chk("way1_fill_cyc", cyc, 6);
      en_r = 1'b1; addr_rw = 32'h2050;
      @(posedge clk); #1;
      chk("back_cs", {31'd0, mem_cs_o}, 32'd1);
      chk("back_we", {31'd0, mem_we_o}, 32'd1);
      chk("back_addr", mem_addr_o, 32'h0050);
      @(posedge clk); #1;
      rst = 1'b0; #1;
      chk("abort_cs", {31'd0, mem_cs_o}, 32'd0);
      chk("abort_addr", mem_addr_o, 32'd0);
      en_r = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      access(1, 0, 32'h2050, 0, cyc, rd);
      chk("after_abort_cyc", cyc, 6);
      chk("after_abort_rd", rd, pat(32'h2050));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
